seq_alu_n: RTL

Parametrised, registered successor to the lab combinational ALU. Operands are W bits wide and the result is 2W bits. The block adds three things: a registered result, accumulator feedback so chained operations can reuse the previous result, and a multi-cycle shift-add multiply with a start/busy/done handshake. It sits between the switch/key inputs and the LEDR/HEX display logic on the board top level.

---
 rtl/alu_pkg.sv | 12 +
 rtl/ripple_adder_n.sv | 18 +
 rtl/seq_alu_n.sv | 87 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encodings shared by the sequential ALU
package alu_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SEXT = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_CAT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_HOLD = 3'b111;
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: N-bit ripple-carry chain of 1-bit full adders
module ripple_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[N];
endmodule

// File: rtl/seq_alu_n.sv
// seq_alu_n: registered ALU with accumulator feedback and shift-add multiply
module seq_alu_n
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    input  logic           start,
    input  logic [2:0]     Function,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           use_acc,
    output logic [2*W-1:0] ALUout,
    output logic           busy,
    output logic           done
);
    localparam int CW = $clog2(W + 1);
    state_t state, state_n;
    logic [W-1:0] bop, add_b, add_s, mplier;
    logic add_co, sub, mul_co, take, last;
    logic [2*W-1:0] res, mcand, prod, mul_s;
    logic [CW-1:0] cnt;
    assign bop   = use_acc ? ALUout[W-1:0] : B;
    assign sub   = Function == OP_SUB;
    assign add_b = sub ? ~bop : bop;
    assign take  = state == S_IDLE && start;
    assign last  = state == S_MUL && cnt == CW'(W - 1);
    assign busy  = state == S_MUL;
    ripple_adder_n #(.N(W)) u_add (
        .a(A), .b(add_b), .cin(sub), .sum(add_s), .cout(add_co)
    );
    ripple_adder_n #(.N(2 * W)) u_mac (
        .a(prod), .b(mplier[0] ? mcand : '0), .cin(1'b0), .sum(mul_s), .cout(mul_co)
    );
    // single-cycle result select; mul and hold leave the result unchanged
    always_comb begin
        res = ALUout;
        case (Function)
            OP_ADD:  res = {{(W-1){1'b0}}, add_co, add_s};
            OP_SUB:  res = {{W{~add_co}}, add_s};
            OP_SEXT: res = {{W{bop[W-1]}}, bop};
            OP_OR:   res = {{(2*W-1){1'b0}}, |{A, bop}};
            OP_AND:  res = {{(2*W-1){1'b0}}, &{A, bop}};
            OP_CAT:  res = {A, bop};
            default: res = ALUout;
        endcase
    end
    // next state: enter MUL on a multiply start, leave after the W-th iteration
    always_comb begin
        state_n = state;
        if (take && Function == OP_MUL) state_n = S_MUL;
        else if (last) state_n = S_IDLE;
    end
    // state register
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) state <= S_IDLE;
        else state <= state_n;
    end
    // datapath: result, done pulse and shift-add registers
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            ALUout <= '0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else begin
            done <= (take && Function != OP_MUL) || last;
            if (take && Function == OP_MUL) begin
                mcand  <= {{W{1'b0}}, A};
                mplier <= bop;
                prod   <= '0;
                cnt    <= '0;
            end else if (take) begin
                ALUout <= res;
            end else if (state == S_MUL) begin
                prod   <= mul_s;
                mcand  <= mcand << 1;
                mplier <= {mul_co, mplier[W-1:1]};
                cnt    <= cnt + CW'(1);
                if (last) ALUout <= mul_s;
            end
        end
    end
endmodule
